gpp_comms_buffer: RTL

Buffering stage between the general purpose processor (GPP) datapath and the communications processor of the photonic interconnect.
- RX path: an 8-deep FIFO absorbs words from the comms processor. The datapath reads the FIFO head as RAM_rx_data_out and polls data_rx_flag.
- TX path: a one-entry holding register captures gpp_tx_data on a datapath transfer request. It then drives a valid/ready handshake to the comms processor.
- gpp_trf_cp tells the datapath when a new transfer can be accepted.

---
 rtl/gpp_comms_pkg.sv | 10 +
 rtl/comms_rx_fifo.sv | 68 ++++++
 rtl/gpp_comms_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/gpp_comms_pkg.sv
// Shared types and constants for the GPP <-> comms-processor buffering stage.
package gpp_comms_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/comms_rx_fifo.sv
// RX FIFO: power-of-two deep circular buffer with zero-bubble head output.
module comms_rx_fifo #(
    parameter int DATA_W   = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic                        rd_req,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        not_empty,
    output logic [$clog2(RX_DEPTH):0]   count,
    output logic                        underflow
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full      = (cnt == CW'(RX_DEPTH));
    assign empty     = (cnt == '0);
    // Ready is forced low while reset is held so no word is taken in the reset cycle.
    assign wr_ready  = !full && rst;
    assign push      = wr_valid && wr_ready;
    assign pop       = rd_req && !empty;
    assign underflow = rd_req && empty && rst;

    assign not_empty = !empty;
    assign count     = cnt;
    assign rd_data   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpp_comms_buffer.sv
// Buffering stage between the GPP datapath and the comms processor: RX FIFO,
// one-entry TX holding register with valid/ready handshake, sticky error flags.
module gpp_comms_buffer #(
    parameter int DATA_W   = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           rx_data_in,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [DATA_W-1:0]           RAM_rx_data_out,
    output logic                        data_rx_flag,
    input  logic                        gpp_rtr_dp,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic [DATA_W-1:0]           gpp_tx_data,
    input  logic                        gpp_trf_dp,
    output logic                        gpp_trf_cp,
    output logic [DATA_W-1:0]           tx_data_out,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic                        err_clear,
    output logic                        rx_underflow,
    output logic                        tx_collision
);

    import gpp_comms_pkg::*;

    tx_state_t         tx_state_q;
    tx_state_t         tx_state_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_data_d;
    logic              rx_underflow_q;
    logic              tx_collision_q;
    logic              underflow_evt;
    logic              collision_evt;

    comms_rx_fifo #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (rx_data_in),
        .wr_valid  (rx_valid),
        .wr_ready  (rx_ready),
        .rd_req    (gpp_rtr_dp),
        .rd_data   (RAM_rx_data_out),
        .not_empty (data_rx_flag),
        .count     (rx_count),
        .underflow (underflow_evt)
    );

    // A request while busy is dropped, even in the cycle the handshake completes.
    assign collision_evt = gpp_trf_dp && (tx_state_q == TX_SEND);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (gpp_trf_dp) begin
                    tx_data_d  = gpp_tx_data;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_ready) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q     <= TX_IDLE;
            tx_data_q      <= '0;
            rx_underflow_q <= 1'b0;
            tx_collision_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            if (underflow_evt) begin
                rx_underflow_q <= 1'b1;
            end else if (err_clear) begin
                rx_underflow_q <= 1'b0;
            end
            if (collision_evt) begin
                tx_collision_q <= 1'b1;
            end else if (err_clear) begin
                tx_collision_q <= 1'b0;
            end
        end
    end

    assign gpp_trf_cp   = (tx_state_q == TX_IDLE);
    assign tx_valid     = (tx_state_q == TX_SEND);
    assign tx_data_out  = tx_data_q;
    assign rx_underflow = rx_underflow_q;
    assign tx_collision = tx_collision_q;

endmodule
